// File: rtl/rtaylor_in_feeder_if.sv
// Bundle between the four sample producers, the processor input decoder and
// the rtaylor_in_feeder FIFO block.
interface rtaylor_in_feeder_if #(
  parameter int DW    = 19,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Producer side: channel k transfers on an edge where s_valid[k] and s_ready[k]
  // are both high. s_ready[k] depends only on registered occupancy, never on s_valid
  // or req_in. A producer may hold s_valid while s_ready is low; that word is not
  // taken until s_ready is high at an edge.
  logic [4*DW-1:0]      s_data;
  logic [3:0]           s_valid;
  logic [3:0]           s_ready;
  logic [3:0]           req_in;
  logic signed [DW-1:0] io_in;
  logic [4*LW-1:0]      level;
  logic [3:0]           underflow;
  logic                 req_err;
  logic                 clr_flags;

  modport master (
    output s_data, s_valid, req_in, clr_flags,
    input  s_ready, io_in, level, underflow, req_err
  );

  modport slave (
    input  s_data, s_valid, req_in, clr_flags,
    output s_ready, io_in, level, underflow, req_err
  );
endinterface

// File: rtl/rtaylor_in_feeder.sv
// Four show-ahead sample FIFOs feeding the int-to-float converter via a one-hot read.
// Optional macro RTAYLOR_FEEDER_HOLD_EN replays the last popped sample on underflow.
module rtaylor_in_feeder #(
  parameter int DW    = 19,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  rtaylor_in_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [LW-1:0] level_q  [4];
  logic [LW-1:0] level_d  [4];
  logic [DW-1:0] head     [4];
  logic [3:0]    underflow_q;
  logic [3:0]    underflow_d;
  logic          req_err_q;
  logic          req_err_d;

  logic [3:0]    full;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [3:0]    uf_evt;
  logic          req_onehot;
  logic          req_multi;

`ifdef RTAYLOR_FEEDER_HOLD_EN
  logic [DW-1:0] hold_q [4];
`endif

  // Request decode: a read is legal only when exactly one channel is selected.
  always_comb begin
    req_onehot = (bus.req_in != 4'b0000) &&
                 ((bus.req_in & (bus.req_in - 4'd1)) == 4'b0000);
    req_multi  = (bus.req_in != 4'b0000) && !req_onehot;
  end

  always_comb begin
    full   = '0;
    push   = '0;
    pop    = '0;
    uf_evt = '0;
    for (int k = 0; k < 4; k++) begin
      head[k]   = mem_q[k][rd_ptr_q[k]];
      full[k]   = (level_q[k] == LW'(DEPTH));
      push[k]   = bus.s_valid[k] && !full[k];
      pop[k]    = req_onehot && bus.req_in[k] && (level_q[k] != '0);
      uf_evt[k] = req_onehot && bus.req_in[k] && (level_q[k] == '0);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      level_d[k]  = level_q[k];
      if (push[k]) begin
        wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
      end
      case ({push[k], pop[k]})
        2'b10:   level_d[k] = level_q[k] + LW'(1);
        2'b01:   level_d[k] = level_q[k] - LW'(1);
        default: level_d[k] = level_q[k];
      endcase
    end
  end

  // Flag events take precedence over a simultaneous clear.
  always_comb begin
    underflow_d = (bus.clr_flags ? 4'b0000 : underflow_q) | uf_evt;
    req_err_d   = (bus.clr_flags ? 1'b0 : req_err_q) | req_multi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        level_q[k]  <= '0;
      end
      underflow_q <= '0;
      req_err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        level_q[k]  <= level_d[k];
      end
      underflow_q <= underflow_d;
      req_err_q   <= req_err_d;
    end
  end

  // Storage has no reset; stale words are unreachable once pointers and levels clear.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst && push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= bus.s_data[k*DW +: DW];
      end
    end
  end

`ifdef RTAYLOR_FEEDER_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pop[k]) begin
          hold_q[k] <= head[k];
        end
      end
    end
  end
`endif

  // Zero-latency read mux: head of the selected channel, or the underflow value.
  always_comb begin
    bus.io_in = '0;
    for (int k = 0; k < 4; k++) begin
      if (req_onehot && bus.req_in[k]) begin
        if (level_q[k] != '0) begin
          bus.io_in = head[k];
        end else begin
`ifdef RTAYLOR_FEEDER_HOLD_EN
          bus.io_in = hold_q[k];
`else
          bus.io_in = '0;
`endif
        end
      end
    end
  end

  always_comb begin
    bus.s_ready = '0;
    bus.level   = '0;
    for (int k = 0; k < 4; k++) begin
      bus.s_ready[k]          = !full[k];
      bus.level[k*LW +: LW]   = level_q[k];
    end
    bus.underflow = underflow_q;
    bus.req_err   = req_err_q;
  end
endmodule

// File: doc/rtaylor_in_feeder.md
RTAYLOR_IN_FEEDER -- requirements
Module: rtaylor_in_feeder

Interface
REQ-001 SHALL have parameter DW, default 19, meaning sample width in bits (signed, two's complement).
REQ-002 SHALL have parameter DEPTH, default 4, meaning entries per channel FIFO; a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_data, input, 4*DW bits: producer samples; channel k occupies bits [k*DW +: DW].
REQ-006 SHALL have port s_valid, input, 4 bits: per-channel producer valid.
REQ-007 SHALL have port s_ready, output, 4 bits: per-channel FIFO not full.
REQ-008 SHALL have port req_in, input, 4 bits: one-hot decoded read request from the processor input decoder.
REQ-009 SHALL have port io_in, output, DW bits, signed: sample presented to the int-to-float converter.
REQ-010 SHALL have port level, output, 4*($clog2(DEPTH)+1) bits: per-channel occupancy.
REQ-011 SHALL have port underflow, output, 4 bits: sticky per-channel flag for a read while empty.
REQ-012 SHALL have port req_err, output, 1 bit: sticky flag for a req_in value with more than one bit set.
REQ-013 SHALL have port clr_flags, input, 1 bit: clears underflow and req_err.

Function
REQ-014 SHALL implement four independent show-ahead FIFOs of DEPTH x DW, one per channel.
REQ-015 SHALL push channel k on a rising edge where s_valid[k] and s_ready[k] are both 1.
REQ-016 SHALL drive s_ready[k] = (level[k] != DEPTH), combinationally from registered state; a pop in the same cycle does not raise s_ready.
REQ-017 SHALL drive io_in combinationally: when req_in is one-hot with bit k set, io_in is the head of FIFO k (zero added latency); otherwise io_in is 0.
REQ-018 SHALL pop FIFO k on a rising edge where req_in is one-hot with bit k set and level[k] > 0; the next head is presented in the following cycle.
REQ-019 SHALL, when req_in[k] is one-hot and level[k] = 0, skip the pop, drive io_in per REQ-036/037, and set underflow[k] at that edge.
REQ-020 SHALL, on a same-edge push and pop on channel k, leave level[k] unchanged and preserve FIFO order.
REQ-021 SHALL, on a same-edge push to an empty channel k with req_in[k], treat the cycle as an underflow read; the pushed sample becomes visible the next cycle.
REQ-022 SHALL, when req_in has two or more bits set, pop nothing, output io_in = 0, and set req_err.
REQ-023 SHALL treat req_in = 0 as idle: no pop and io_in = 0.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL pass samples unmodified: no sign extension, truncation or rounding.
REQ-026 SHALL, when clr_flags and a new flag event occur on the same edge, leave the flag set (set wins).
REQ-027 SHALL keep each pop tied to its request edge; a multi-cycle req_in[k] pops once per cycle.

Reset
REQ-028 SHALL, on any rising edge with rst = 1, zero all pointers and levels and clear underflow, req_err and the held-sample registers.
REQ-029 SHALL keep s_ready = 4'b1111 after reset.
REQ-030 SHALL keep io_in = 0 after reset unless a valid one-hot req_in selects a nonempty channel.
REQ-031 SHALL, during a cycle with rst = 1, discard any push or pop presented; rst takes priority over every other event.
REQ-032 SHALL, when rst is asserted mid-stream, make all queued samples unrecoverable.

Configuration
REQ-033 SHALL support macro RTAYLOR_FEEDER_HOLD_EN.
REQ-034 SHALL, with RTAYLOR_FEEDER_HOLD_EN defined, keep a per-channel register of the last successfully popped sample (reset value 0).
REQ-035 SHALL, without RTAYLOR_FEEDER_HOLD_EN, omit the REQ-034 registers.
REQ-036 SHALL, with RTAYLOR_FEEDER_HOLD_EN defined, present the REQ-034 register on io_in during an underflow read.
REQ-037 SHALL, without RTAYLOR_FEEDER_HOLD_EN, present 0 on io_in during an underflow read.
REQ-038 SHALL set the underflow flags identically in both builds.

Verification
REQ-039 SHALL cover: push 5, -3, 7 on channel 2, then req_in = 4'b0100 for three cycles -> io_in 5, -3, 7 in order; level[2] goes 3, 2, 1, 0.
REQ-040 SHALL cover: fill channel 0 with 4 samples -> s_ready[0] = 0; the 5th push is ignored and level[0] stays 4.
REQ-041 SHALL cover: req_in = 4'b0001 on empty channel 0 after popping -262144 -> underflow[0] = 1; io_in = -262144 with the macro, 0 without it.
REQ-042 SHALL cover: req_in = 4'b0011 with both channels nonempty -> io_in = 0, req_err = 1, both levels unchanged.
REQ-043 SHALL cover: same-edge push 9 and pop on channel 3 holding {1, 2} -> io_in = 1 that cycle, level[3] stays 2, then pops yield 2 then 9.
REQ-044 SHALL cover: rst for one cycle with channel 1 at level 3 -> next cycle level[1] = 0, s_ready = 4'b1111, flags cleared.
